// File: rtl/alu_clock_gen_if.sv
// Control and status bundle between a timebase user (master) and the
// alu_clock_gen divider (slave). Widths follow the divider's parameters.
interface alu_clock_gen_if #(
  parameter int CNT_W = 16,
  parameter int CYC_W = 32
);
  logic             en;
  logic             load;
  logic [CNT_W-1:0] half_period;
  logic             clock;
  logic             rise;
  logic             fall;
  logic [CYC_W-1:0] cycles;

  modport master (
    output en, load, half_period,
    input  clock, rise, fall, cycles
  );

  modport slave (
    input  en, load, half_period,
    output clock, rise, fall, cycles
  );
endinterface

// File: rtl/alu_clock_gen.sv
// Programmable 50%-duty clock divider with rise/fall strobes and a running
// count of divided-clock rising edges. Every output comes straight from a flop.
module alu_clock_gen #(
  parameter int CNT_W        = 16,
  parameter int CYC_W        = 32,
  parameter int DEFAULT_HALF = 1
) (
  input  logic           clk,
  input  logic           reset,
  alu_clock_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] half_sat;
  logic             clock_q, clock_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;
  logic             toggle;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    shadow_d = shadow_q;
    clock_d  = clock_q;
    half_sat = (bus.half_period == '0) ? ONE : bus.half_period;
    toggle   = bus.en && (cnt_q == (active_q - ONE));

    if (bus.load) begin
      shadow_d = half_sat;
    end

    if (bus.en) begin
      if (toggle) begin
        // The new half-period takes effect only from the next phase onward.
        cnt_d    = '0;
        clock_d  = ~clock_q;
        active_d = shadow_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      // While stopped the active length tracks the shadow (or a same-edge load);
      // a changed length restarts the phase so cnt can never overrun it.
      active_d = bus.load ? half_sat : shadow_q;
      if (active_d != active_q) begin
        cnt_d = '0;
      end
    end

    rise_d   = toggle && !clock_q;
    fall_d   = toggle && clock_q;
    cycles_d = cycles_q + CYC_W'(rise_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      active_q <= HALF_RST;
      shadow_q <= HALF_RST;
      clock_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cycles_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      clock_q  <= clock_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cycles_q <= cycles_d;
    end
  end

  assign bus.clock  = clock_q;
  assign bus.rise   = rise_q;
  assign bus.fall   = fall_q;
  assign bus.cycles = cycles_q;

endmodule

// File: tb/tb_alu_clock_gen.sv
// Bench for alu_clock_gen: hand-derived vector table, async reset check,
// random scoreboard run against a reference model, and a 4-bit cycle wrap run.
module tb_alu_clock_gen;

  localparam int CNT_W = 16;

  typedef struct {
    logic             en;
    logic             load;
    logic [CNT_W-1:0] hp;
    logic             clock;
    logic             rise;
    logic             fall;
    logic [31:0]      cycles;
  } vec_t;

  typedef struct {
    logic        clock;
    logic        rise;
    logic        fall;
    logic [31:0] cycles;
    int          tag;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  alu_clock_gen_if #(.CNT_W(CNT_W), .CYC_W(32)) bus ();
  alu_clock_gen_if #(.CNT_W(CNT_W), .CYC_W(4))  bus_w ();

  alu_clock_gen #(.CNT_W(CNT_W), .CYC_W(32), .DEFAULT_HALF(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  alu_clock_gen #(.CNT_W(CNT_W), .CYC_W(4), .DEFAULT_HALF(1)) dut_w (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_w.slave)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  vec_t vt[33];

  // reference model state
  logic [CNT_W-1:0] m_cnt, m_active, m_shadow;
  logic             m_clock;
  logic [31:0]      m_cycles;

  function automatic void chk(string nm, int tag, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, required %0h", nm, tag, act, req);
    end
  endfunction

  function automatic vec_t mk(logic en, logic ld, int hp, logic c, logic r, logic f, int cy);
    vec_t v;
    v.en = en; v.load = ld; v.hp = CNT_W'(hp);
    v.clock = c; v.rise = r; v.fall = f; v.cycles = 32'(cy);
    return v;
  endfunction

  task automatic drive(input logic en, input logic ld, input logic [CNT_W-1:0] hp);
    bus.en = en;   bus.load = ld;   bus.half_period = hp;
    bus_w.en = en; bus_w.load = ld; bus_w.half_period = hp;
  endtask

  // Push the expectation, take one clk edge, then pop and compare both DUTs.
  task automatic step_check(input exp_t e);
    exp_t g;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("clock", g.tag, 32'(bus.clock), 32'(g.clock));
    chk("rise",  g.tag, 32'(bus.rise),  32'(g.rise));
    chk("fall",  g.tag, 32'(bus.fall),  32'(g.fall));
    chk("cycles", g.tag, bus.cycles, g.cycles);
    chk("cycles4", g.tag, 32'(bus_w.cycles), {28'd0, g.cycles[3:0]});
    $display("step %0d: clock=%0b rise=%0b fall=%0b cycles=%0d", g.tag,
             bus.clock, bus.rise, bus.fall, bus.cycles);
  endtask

  task automatic model_reset();
    m_cnt = '0; m_active = CNT_W'(1); m_shadow = CNT_W'(1);
    m_clock = 1'b0; m_cycles = '0;
  endtask

  task automatic model_step(input logic en, input logic ld, input logic [CNT_W-1:0] hp,
                            output exp_t e);
    logic [CNT_W-1:0] hs, na;
    logic             tg;
    hs = (hp == 0) ? CNT_W'(1) : hp;
    tg = en && (m_cnt == m_active - CNT_W'(1));
    e.rise = 1'b0; e.fall = 1'b0;
    if (en) begin
      if (tg) begin
        e.rise = !m_clock; e.fall = m_clock;
        m_clock = !m_clock; m_cnt = '0; m_active = m_shadow;
      end else begin
        m_cnt = m_cnt + CNT_W'(1);
      end
    end else begin
      na = ld ? hs : m_shadow;
      if (na != m_active) m_cnt = '0;
      m_active = na;
    end
    if (ld) m_shadow = hs;
    if (e.rise) m_cycles = m_cycles + 32'd1;
    e.clock = m_clock; e.cycles = m_cycles;
  endtask

  initial begin
    exp_t e;
    logic en_r, ld_r;
    logic [CNT_W-1:0] hp_r;

    // half=1 start, then load 3, load 0, load 4 with a 5-clk stall, load 2 while stopped
    vt[0]  = mk(1,0,0, 1,1,0,1); vt[1]  = mk(1,0,0, 0,0,1,1);
    vt[2]  = mk(1,0,0, 1,1,0,2); vt[3]  = mk(1,0,0, 0,0,1,2);
    vt[4]  = mk(1,0,0, 1,1,0,3); vt[5]  = mk(1,1,3, 0,0,1,3);
    vt[6]  = mk(1,0,0, 1,1,0,4); vt[7]  = mk(1,0,0, 1,0,0,4);
    vt[8]  = mk(1,0,0, 1,0,0,4); vt[9]  = mk(1,0,0, 0,0,1,4);
    vt[10] = mk(1,0,0, 0,0,0,4); vt[11] = mk(1,0,0, 0,0,0,4);
    vt[12] = mk(1,0,0, 1,1,0,5); vt[13] = mk(1,1,0, 1,0,0,5);
    vt[14] = mk(1,0,0, 1,0,0,5); vt[15] = mk(1,0,0, 0,0,1,5);
    vt[16] = mk(1,0,0, 1,1,0,6); vt[17] = mk(1,0,0, 0,0,1,6);
    vt[18] = mk(1,0,0, 1,1,0,7); vt[19] = mk(1,1,4, 0,0,1,7);
    vt[20] = mk(1,0,0, 1,1,0,8); vt[21] = mk(1,0,0, 1,0,0,8);
    vt[22] = mk(0,0,0, 1,0,0,8); vt[23] = mk(0,0,0, 1,0,0,8);
    vt[24] = mk(0,0,0, 1,0,0,8); vt[25] = mk(0,0,0, 1,0,0,8);
    vt[26] = mk(0,0,0, 1,0,0,8); vt[27] = mk(1,0,0, 1,0,0,8);
    vt[28] = mk(1,0,0, 1,0,0,8); vt[29] = mk(1,0,0, 0,0,1,8);
    vt[30] = mk(0,1,2, 0,0,0,8); vt[31] = mk(1,0,0, 0,0,0,8);
    vt[32] = mk(1,0,0, 1,1,0,9);

    // Reset held with clk running and en high: outputs must stay cleared.
    drive(1'b1, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clock",  0, 32'(bus.clock), 32'd0);
    chk("rst_rise",   0, 32'(bus.rise),  32'd0);
    chk("rst_fall",   0, 32'(bus.fall),  32'd0);
    chk("rst_cycles", 0, bus.cycles,     32'd0);
    #2 reset = 1'b1;

    for (int i = 0; i < 33; i++) begin
      drive(vt[i].en, vt[i].load, vt[i].hp);
      e.clock = vt[i].clock; e.rise = vt[i].rise; e.fall = vt[i].fall;
      e.cycles = vt[i].cycles; e.tag = i;
      step_check(e);
    end

    // Async reset mid-high-phase, between clk edges.
    #2 reset = 1'b0;
    #1;
    chk("arst_clock",  100, 32'(bus.clock), 32'd0);
    chk("arst_rise",   100, 32'(bus.rise),  32'd0);
    chk("arst_cycles", 100, bus.cycles,     32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Random run against the reference model.
    model_reset();
    for (int i = 0; i < 200; i++) begin
      en_r = ($urandom_range(0, 9) < 8);
      ld_r = ($urandom_range(0, 9) < 2);
      hp_r = CNT_W'($urandom_range(0, 4));
      drive(en_r, ld_r, hp_r);
      model_step(en_r, ld_r, hp_r, e);
      e.tag = 200 + i;
      step_check(e);
    end

    // Cycle counter wrap with half=1 on the 4-bit instance.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, '0);
    for (int k = 1; k <= 34; k++) begin
      e.clock = k[0]; e.rise = k[0]; e.fall = !k[0];
      e.cycles = 32'((k + 1) / 2); e.tag = 500 + k;
      step_check(e);
      if (k == 29) chk("wrap15", k, 32'(bus_w.cycles), 32'd15);
      if (k == 31) chk("wrap0",  k, 32'(bus_w.cycles), 32'd0);
      if (k == 33) chk("wrap1",  k, 32'(bus_w.cycles), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
